load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the CPU datapath: takes the ALU result as the address and the register-file second read as store data.
- Runs a multi-cycle request/acknowledge transaction on the external data bus and returns read_data to the datapath result mux.
- Asserts stall to freeze PC and register writes until the access completes.
- Handles byte/word steering, alignment checks and bus timeout.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_align.sv | 34 +++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, fault codes and the
// full-word byte-enable constant.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        FAULT_NONE = 3'd0,
        MISALIGN   = 3'd1,
        TIMEOUT    = 3'd2,
        BUS_ERR    = 3'd3,
        CONFLICT   = 3'd4
    } fault_e;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU (combinational).
// Store side: st_off/st_byte/wdata -> be, st_data.  Load side: rdata -> ld_data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic        st_byte,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_off,
    input  logic        ld_byte,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    always_comb begin
        be      = BE_WORD;
        st_data = wdata;
        if (st_byte) begin
            be      = 4'b0001 << st_off;
            // replicate so the slave can take the byte from any lane
            st_data = {4{wdata[7:0]}};
        end
    end

    always_comb begin
        ld_data = rdata;
        if (ld_byte) begin
            ld_data = {24'h0, rdata[{ld_off, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs a req/ack bus transaction for loads and stores.
// Ports: CPU side (mem_read/mem_write/byte_access/addr/wdata -> read_data,
// stall, fault, fault_code) and bus side (bus_req/we/addr/wdata/be, bus_ack/
// rdata/err).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        byte_access,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             conflict_q;
    logic [1:0]       off_q;
    logic             byte_q;

    logic        req;
    logic        misalign;
    logic        last;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [31:0] rd_c;

    assign req      = mem_read | mem_write;
    assign misalign = ~byte_access & (addr[1:0] != 2'b00);
    assign last     = (cnt == CNT_LAST);
    assign stall    = req & (state != DONE);

    lsu_lane_align u_align (
        .st_off  (addr[1:0]),
        .st_byte (byte_access),
        .wdata   (wdata),
        .be      (be_c),
        .st_data (wd_c),
        .ld_off  (off_q),
        .ld_byte (byte_q),
        .rdata   (bus_rdata),
        .ld_data (rd_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req) state_n = misalign ? DONE : BUSY;
            BUSY:    if (bus_ack || last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data  <= '0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= 4'h0;
            cnt        <= '0;
            conflict_q <= 1'b0;
            off_q      <= 2'b00;
            byte_q     <= 1'b0;
        end else begin
            fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req && misalign) begin
                        fault      <= 1'b1;
                        fault_code <= MISALIGN;
                        read_data  <= '0;
                    end else if (req) begin
                        // read+write together is executed as a write
                        bus_req    <= 1'b1;
                        bus_we     <= mem_write;
                        bus_addr   <= {addr[31:2], 2'b00};
                        bus_wdata  <= wd_c;
                        bus_be     <= be_c;
                        conflict_q <= mem_read & mem_write;
                        off_q      <= addr[1:0];
                        byte_q     <= byte_access;
                    end
                end
                BUSY: begin
                    // ack takes priority over a timeout in the same cycle
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_err) begin
                            read_data  <= '0;
                            fault      <= 1'b1;
                            fault_code <= BUS_ERR;
                        end else begin
                            read_data  <= rd_c;
                            fault      <= conflict_q;
                            fault_code <= conflict_q ? CONFLICT : FAULT_NONE;
                        end
                    end else if (last) begin
                        bus_req    <= 1'b0;
                        read_data  <= '0;
                        fault      <= 1'b1;
                        fault_code <= TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model plus a
// per-cycle compare process and literal pins on the directed vectors.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, byte_access;
    logic [31:0] addr, wdata;
    logic [31:0] read_data;
    logic        stall, fault;
    logic [2:0]  fault_code;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .byte_access (byte_access),
        .addr        (addr),
        .wdata       (wdata),
        .read_data   (read_data),
        .stall       (stall),
        .fault       (fault),
        .fault_code  (fault_code),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int stalls = 0;

    logic        chk_en = 0, e_rst = 0, e_first = 0;
    logic        e_stall = 0, e_req = 0, e_we = 0, e_done = 0, e_fault = 0;
    logic        e_chk_rd = 0, e_chk_wd = 0;
    logic [31:0] e_addr = 0, e_wd = 0, e_rd = 0;
    logic [3:0]  e_be = 0;
    logic [2:0]  e_code = 0;
    logic        l_rd_en = 0, l_be_en = 0, l_wd_en = 0;
    logic [31:0] l_rd = 0, l_wd = 0;
    logic [3:0]  l_be = 0;
    int          l_stalls = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_first) stalls = 0;
            if (stall) stalls++;
            chk("stall", 32'(stall), 32'(e_stall));
            chk("bus_req", 32'(bus_req), 32'(e_req));
            if (e_rst) begin
                chk("rst_read_data", read_data, 32'd0);
                chk("rst_bus_addr", bus_addr, 32'd0);
                chk("rst_bus_wdata", bus_wdata, 32'd0);
                chk("rst_bus_be", 32'(bus_be), 32'd0);
                chk("rst_bus_we", 32'(bus_we), 32'd0);
                chk("rst_fault", 32'(fault), 32'd0);
                chk("rst_fault_code", 32'(fault_code), 32'(FAULT_NONE));
            end else begin
                if (!e_done) chk("fault_idle", 32'(fault), 32'd0);
                if (e_req) begin
                    chk("bus_addr", bus_addr, e_addr);
                    chk("bus_be", 32'(bus_be), 32'(e_be));
                    chk("bus_we", 32'(bus_we), 32'(e_we));
                    if (e_chk_wd) chk("bus_wdata", bus_wdata, e_wd);
                    if (l_be_en) chk("lit_bus_be", 32'(bus_be), 32'(l_be));
                    if (l_wd_en) chk("lit_bus_wdata", bus_wdata, l_wd);
                end
                if (e_done) begin
                    chk("fault", 32'(fault), 32'(e_fault));
                    if (e_fault) chk("fault_code", 32'(fault_code), 32'(e_code));
                    if (e_chk_rd) chk("read_data", read_data, e_rd);
                    if (l_rd_en) chk("lit_read_data", read_data, l_rd);
                    if (l_stalls > 0) chk("stall_count", 32'(stalls), 32'(l_stalls));
                end
            end
        end
    end

    task automatic run_op(
        input logic rd, input logic wr, input logic byt,
        input logic [31:0] a, input logic [31:0] wd,
        input int dly, input logic err, input logic [31:0] rdata,
        input int lst,
        input logic lrde, input logic [31:0] lrd,
        input logic lbee, input logic [3:0] lbe,
        input logic lwde, input logic [31:0] lwd);
        logic mis, acked, tmo, berr;
        int   off, busy, n;
        fault_e code;
        mis   = !byt && (a[1:0] != 2'b00);
        off   = int'(a[1:0]);
        acked = !mis && (dly < TMO);
        tmo   = !mis && !acked;
        berr  = acked && err;
        busy  = acked ? dly + 1 : TMO;
        n     = mis ? 1 : 1 + busy;
        if (mis)           code = MISALIGN;
        else if (tmo)      code = TIMEOUT;
        else if (berr)     code = BUS_ERR;
        else if (rd && wr) code = CONFLICT;
        else               code = FAULT_NONE;
        e_code   = code;
        e_addr   = a & ~32'h3;
        e_we     = wr;
        e_be     = byt ? (4'b0001 << off) : 4'hF;
        e_wd     = byt ? {24'h0, wd[7:0]} * 32'h01010101 : wd;
        e_chk_wd = wr;
        e_rd     = (tmo || berr) ? 32'd0 :
                   byt ? ((rdata >> (8 * off)) & 32'hFF) : rdata;
        e_chk_rd = tmo || berr || (rd && !wr && !mis);
        l_rd_en = lrde; l_rd = lrd;
        l_be_en = lbee; l_be = lbe;
        l_wd_en = lwde; l_wd = lwd;
        l_stalls = lst;
        mem_read = rd; mem_write = wr; byte_access = byt;
        addr = a; wdata = wd; bus_rdata = rdata;
        for (int k = 0; k <= n; k++) begin
            e_first = (k == 0);
            e_stall = (k < n);
            e_req   = !mis && (k >= 1) && (k < n);
            e_done  = (k == n);
            e_fault = e_done && (code != FAULT_NONE);
            bus_ack = acked && (k == 1 + dly);
            bus_err = bus_ack && err;
            @(posedge clk); #1;
        end
        mem_read = 0; mem_write = 0; byte_access = 0;
        bus_ack = 0; bus_err = 0;
        e_first = 0; e_stall = 0; e_req = 0; e_done = 0; e_fault = 0;
        l_rd_en = 0; l_be_en = 0; l_wd_en = 0; l_stalls = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1; mem_read = 0; mem_write = 0; byte_access = 0;
        addr = 0; wdata = 0; bus_ack = 0; bus_rdata = 0; bus_err = 0;
        chk_en = 1; e_rst = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0; e_rst = 0;
        @(posedge clk); #1;

        run_op(1, 0, 0, 32'h100, 0, 3, 0, 32'hDEADBEEF, 5,
               1, 32'hDEADBEEF, 1, 4'hF, 0, 0);
        run_op(0, 1, 1, 32'h203, 32'h000000A5, 0, 0, 0, 2,
               0, 0, 1, 4'b1000, 1, 32'hA5A5A5A5);
        run_op(1, 0, 1, 32'h302, 0, 1, 0, 32'h11223344, 3,
               1, 32'h00000022, 1, 4'b0100, 0, 0);
        run_op(1, 0, 0, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_op(1, 0, 0, 32'h400, 0, 99, 0, 32'h12345678, 5,
               1, 32'h0, 0, 0, 0, 0);
        run_op(1, 0, 0, 32'h404, 0, 1, 1, 32'h55, 3,
               1, 32'h0, 0, 0, 0, 0);
        run_op(1, 1, 0, 32'h500, 32'h12345678, 0, 0, 32'h9, 2,
               0, 0, 0, 0, 1, 32'h12345678);
        run_op(0, 1, 0, 32'h600, 32'hCAFEF00D, 2, 0, 0, 4,
               0, 0, 1, 4'hF, 1, 32'hCAFEF00D);
        run_op(1, 0, 1, 32'h001, 0, 0, 0, 32'hAABBCCDD, 2,
               1, 32'h000000CC, 1, 4'b0010, 0, 0);

        bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 0;
        @(posedge clk); #1;

        mem_read = 1; addr = 32'h700; byte_access = 0;
        e_addr = 32'h700; e_be = 4'hF; e_we = 0; e_chk_wd = 0;
        e_first = 1; e_stall = 1; e_req = 0;
        @(posedge clk); #1;
        e_first = 0; e_req = 1;
        @(posedge clk); #3;
        reset = 1; e_rst = 1; e_req = 0;
        @(posedge clk); #1;
        mem_read = 0; e_stall = 0;
        @(posedge clk); #1;
        reset = 0; e_rst = 0;
        @(posedge clk); #1;
        run_op(1, 0, 0, 32'h704, 0, 1, 0, 32'h0BADF00D, 3,
               1, 32'h0BADF00D, 0, 0, 0, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
